// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage.
//   Owns the architectural PC and issues sequential fetches (PC+4) over a
//   req/gnt/rvalid handshake. Only one request is outstanding at a time.
//   Each returned word is buffered together with its PC in a DEPTH-entry
//   FIFO that feeds decode through a valid/ready interface. A redirect
//   from the next-PC logic reloads the PC, flushes the FIFO and discards
//   any response that is still in flight.
// Ports:
//   clk, rstn                  clock (rising edge) / async active-low reset
//   redirect_valid/_pc         redirect request and target from next-PC logic
//   pc_out                     PC of the next fetch to be issued
//   imem_req/_addr/_gnt        fetch request channel
//   imem_rvalid/_rdata         fetch response channel
//   id_valid/_ready/_instr/_pc buffer head towards decode
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_out,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

  state_e          state_q, state_d;
  logic            run_q;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [31:0]     buf_instr_q [DEPTH];
  logic [31:0]     buf_pc_q    [DEPTH];

  logic fire, push, pop;

  // run_q holds off the first request until the cycle after reset release.
  assign imem_req  = run_q && (state_q == IDLE) && (count_q < CW'(DEPTH)) && !redirect_valid;
  assign imem_addr = pc_q;
  assign pc_out    = pc_q;

  assign fire = imem_req && imem_gnt;
  // A redirect flushes the buffer, so same-cycle push/pop are suppressed.
  assign push = (state_q == WAIT) && imem_rvalid && !redirect_valid;
  assign pop  = id_valid && id_ready && !redirect_valid;

  assign id_valid = (count_q != '0);
  assign id_instr = id_valid ? buf_instr_q[rptr_q] : '0;
  assign id_pc    = id_valid ? buf_pc_q[rptr_q]    : '0;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    count_d  = count_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;

    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      // An in-flight request whose data has not arrived must be dropped.
      unique case (state_q)
        IDLE:    state_d = IDLE;
        WAIT:    state_d = imem_rvalid ? IDLE : DROP;
        DROP:    state_d = imem_rvalid ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: if (fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = WAIT;
        end
        WAIT: if (imem_rvalid) state_d = IDLE;
        DROP: if (imem_rvalid) state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      run_q    <= 1'b0;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      count_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_instr_q[i] <= '0;
        buf_pc_q[i]    <= '0;
      end
    end else begin
      state_q  <= state_d;
      run_q    <= 1'b1;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      // rdata is only sampled on a valid response in WAIT.
      if (push) begin
        buf_instr_q[wptr_q] <= imem_rdata;
        buf_pc_q[wptr_q]    <= req_pc_q;
      end
    end
  end

endmodule
